// File: rtl/fft_result_normalizer.sv
// FP32 to signed fixed-point Q(OUT_W-FRAC_BITS).FRAC_BITS converter: decode stage, shift/saturate stage, output FIFO.
// Optional saturation counter (sat_count/sat_clr) is built when FFT_NORM_SAT_CNT_EN is defined.
module fft_result_normalizer #(
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 15,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FFT_NORM_SAT_CNT_EN
  ,
  input  logic             sat_clr,
  output logic [15:0]      sat_count
`endif
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int MAG_W = OUT_W + 25;
  localparam logic signed [10:0] SH_OFS  = 11'(150 - FRAC_BITS);
  localparam logic signed [10:0] SH_MAX  = 11'(OUT_W);
  localparam logic signed [10:0] RSH_LIM = 11'sd32;
  localparam logic [MAG_W-1:0]   ONE_M   = MAG_W'(1);
  localparam logic [MAG_W-1:0]   LIM_N   = ONE_M << (OUT_W - 1);
  localparam logic [MAG_W-1:0]   LIM_P   = LIM_N - ONE_M;
  localparam logic [OUT_W-1:0]   MAX_CODE = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]   MIN_CODE = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CW:0]        DEPTH_C  = (CW+1)'(DEPTH);

  logic                r_run;
  logic                r_s1_vld, r_s1_sign;
  logic [7:0]          r_s1_exp;
  logic [22:0]         r_s1_man;
  logic                r_s2_vld, r_s2_sat;
  logic [OUT_W-1:0]    r_s2_data;
  logic [OUT_W:0]      r_mem [DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_cnt;

  logic                w_accept, w_pop;
  logic [CW:0]         w_occ;
  logic signed [10:0]  w_sh, w_rsh;
  logic [23:0]         w_sig;
  logic [MAG_W-1:0]    w_mag;
  logic                w_big, w_sat;
  logic [OUT_W-1:0]    w_data;

  // Words already inside S1/S2 are counted as occupied, so every accepted word has a FIFO slot reserved.
  assign w_occ     = {1'b0, r_cnt} + {{CW{1'b0}}, r_s1_vld} + {{CW{1'b0}}, r_s2_vld};
  assign in_ready  = r_run && (w_occ < DEPTH_C);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign {out_sat, out_data} = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_man  <= '0;
    end else begin
      r_run    <= 1'b1;
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_sign <= in_data[31];
        r_s1_exp  <= in_data[30:23];
        r_s1_man  <= in_data[22:0];
      end
    end
  end

  // Value = {1,m} * 2^(exp - 150 + FRAC_BITS); w_sh is that binary shift applied to the 24-bit significand.
  assign w_sig = {1'b1, r_s1_man};
  assign w_sh  = $signed({3'b000, r_s1_exp}) - SH_OFS;
  assign w_rsh = -w_sh;

  always_comb begin
    w_mag = '0;
    w_big = 1'b0;
    if (!w_sh[10]) begin
      if (w_sh > SH_MAX) w_big = 1'b1;
      else               w_mag = {{(MAG_W-24){1'b0}}, w_sig} << w_sh[5:0];
    end else if (w_rsh < RSH_LIM) begin
      w_mag = {{(MAG_W-24){1'b0}}, w_sig} >> w_rsh[4:0];
    end
  end

  always_comb begin
    w_data = '0;
    w_sat  = 1'b0;
    if (r_s1_exp == 8'hFF) begin
      w_sat = 1'b1;
      if (r_s1_man == '0) w_data = r_s1_sign ? MIN_CODE : MAX_CODE;
    end else if (r_s1_exp != 8'h00) begin
      if (!r_s1_sign) begin
        if (w_big || (w_mag > LIM_P)) begin
          w_data = MAX_CODE;
          w_sat  = 1'b1;
        end else begin
          w_data = w_mag[OUT_W-1:0];
        end
      end else begin
        if (w_big || (w_mag > LIM_N)) begin
          w_data = MIN_CODE;
          w_sat  = 1'b1;
        end else begin
          w_data = -w_mag[OUT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_sat  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_sat  <= w_sat;
        r_s2_data <= w_data;
      end
    end
  end

  // DEPTH is a power of two, so the natural AW-bit pointer wrap is the wrap at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (r_s2_vld) begin
        r_mem[r_wr] <= {r_s2_sat, r_s2_data};
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(r_s2_vld) - CW'(w_pop);
    end
  end

`ifdef FFT_NORM_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_sat_cnt <= '0;
    else if (sat_clr)                                     r_sat_cnt <= '0;
    else if (w_pop && out_sat && (r_sat_cnt != 16'hFFFF)) r_sat_cnt <= r_sat_cnt + 16'd1;
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_fft_result_normalizer.sv
// Bench for fft_result_normalizer: fixed vector table, flow-control/reset sequences, and random traffic
// scored against a real-arithmetic model of the FP32 to fixed-point conversion.
module tb_fft_result_normalizer;
  localparam int OUT_W = 16, FRAC_BITS = 15, DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_sat, out_valid, out_ready;
`ifdef FFT_NORM_SAT_CNT_EN
  logic        sat_clr;
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  fft_result_normalizer #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FFT_NORM_SAT_CNT_EN
    , .sat_clr(sat_clr), .sat_count(sat_count)
`endif
  );

  int n_pass = 0, n_chk = 0;
  logic [16:0] q[$];
  logic last_acc, last_pop;

  typedef struct {
    logic [31:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;
  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: value computed in real arithmetic, magnitude truncated, sign applied afterwards.
  function automatic logic [16:0] ref_conv(input logic [31:0] w);
    int  e;
    real m, v;
    int  q_mag;
    e = int'(w[30:23]);
    if (e == 0) return 17'h0;
    if (e == 255) begin
      if (w[22:0] != 0) return {1'b1, 16'h0000};
      return w[31] ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
    end
    m = 1.0 + real'(w[22:0]) / 8388608.0;
    v = m * (2.0 ** (e - 127 + FRAC_BITS));
    q_mag = (v >= 1.0e6) ? 1000000 : $rtoi(v);
    if (!w[31]) return (q_mag > 32767) ? {1'b1, 16'h7FFF} : {1'b0, 16'(q_mag)};
    return (q_mag > 32768) ? {1'b1, 16'h8000} : {1'b0, 16'(-q_mag)};
  endfunction

  function automatic logic [31:0] rand_word();
    int          r;
    logic [7:0]  e;
    logic [22:0] m;
    r = int'($urandom_range(0, 9));
    m = 23'($urandom);
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else             e = 8'($urandom_range(100, 145));
    if (r == 1 && ($urandom % 2) == 0) m = '0;
    return {1'($urandom), e, m};
  endfunction

  // One clock: sample handshakes at the falling edge, score pops, log accepts, then step past the rising edge.
  task automatic cycle();
    logic [16:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    last_pop = out_valid && out_ready;
    if (last_pop) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL pop_empty: popped %h with no word outstanding, expected no pop", out_data);
      end else begin
        e = q.pop_front();
        chk("pop_data", {16'h0, out_data}, {16'h0, e[15:0]});
        chk("pop_sat", {31'h0, out_sat}, {31'h0, e[16]});
      end
    end
    if (last_acc) q.push_back(ref_conv(in_data));
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (last_acc) break;
    end
    in_valid = 1'b0;
    if (!last_acc) begin
      n_chk++;
      $display("FAIL push_timeout: in_ready stayed 0, expected acceptance of %h", w);
    end
  endtask

  initial begin
    int n_acc, n_vld, t;
    vecs[0]  = '{32'h3F000000, 16'h4000, 1'b0};
    vecs[1]  = '{32'hBE800000, 16'hE000, 1'b0};
    vecs[2]  = '{32'hBF800000, 16'h8000, 1'b0};
    vecs[3]  = '{32'h3F800000, 16'h7FFF, 1'b1};
    vecs[4]  = '{32'h38000000, 16'h0001, 1'b0};
    vecs[5]  = '{32'h37800000, 16'h0000, 1'b0};
    vecs[6]  = '{32'hB7C00000, 16'h0000, 1'b0}; // -0.75 LSB: magnitude truncates to 0
    vecs[7]  = '{32'h7FC00000, 16'h0000, 1'b1};
    vecs[8]  = '{32'hB8000000, 16'hFFFF, 1'b0};
    vecs[9]  = '{32'h7F800000, 16'h7FFF, 1'b1};
    vecs[10] = '{32'hFF800000, 16'h8000, 1'b1};
    vecs[11] = '{32'h00000000, 16'h0000, 1'b0};
    vecs[12] = '{32'h80000001, 16'h0000, 1'b0};
    vecs[13] = '{32'h3F7FFFFF, 16'h7FFF, 1'b0};
    vecs[14] = '{32'hBF7FFFFF, 16'h8001, 1'b0};
    vecs[15] = '{32'hC0000000, 16'h8000, 1'b1};
    vecs[16] = '{32'h7F000000, 16'h7FFF, 1'b1};
    vecs[17] = '{32'h01000000, 16'h0000, 1'b0};
    vecs[18] = '{32'hFFFFFFFF, 16'h0000, 1'b1};

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef FFT_NORM_SAT_CNT_EN
    sat_clr = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_out_sat", {31'h0, out_sat}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1 chk("rel_in_ready_after_edge", {31'h0, in_ready}, 32'h1);

    // Table vectors, one at a time into an empty FIFO: exact two-edge latency plus value.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_data  = vecs[i].din;
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) begin
        n_chk++;
        $display("FAIL vec_ready_timeout: in_ready 0, expected 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("vec_early_valid", {31'h0, out_valid}, 32'h0);
      @(posedge clk); #1;
      chk("vec_valid", {31'h0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_data", i), {16'h0, out_data}, {16'h0, vecs[i].dout});
      chk($sformatf("vec%0d_sat", i), {31'h0, out_sat}, {31'h0, vecs[i].sat});
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: only DEPTH words can be in flight, then stream with simultaneous push and pop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 6; i++) begin
      in_data = rand_word();
      cycle();
      if (last_acc) n_acc++;
    end
    chk("fill_accepted", n_acc, 4);
    chk("fill_in_ready", {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = rand_word();
      cycle();
      chk("stream_out_valid", {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    repeat (10) cycle();
    chk("stream_drained", q.size(), 0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = rand_word();
      out_ready = ($urandom % 4) != 0;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) cycle();
    chk("random_drained", q.size(), 0);

    // Reset with three words buffered: everything is discarded.
    out_ready = 1'b0;
    push_word(32'h3F000000);
    push_word(32'hBE800000);
    push_word(32'h3F800000);
    repeat (3) cycle();
    chk("pre_rst_out_valid", {31'h0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("mid_rst_out_data", {16'h0, out_data}, 32'h0);
    chk("mid_rst_out_sat", {31'h0, out_sat}, 32'h0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_in_ready", {31'h0, in_ready}, 32'h1);
    out_ready = 1'b1;
    n_vld = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) n_vld++;
      cycle();
    end
    chk("no_stale_words", n_vld, 0);

`ifdef FFT_NORM_SAT_CNT_EN
    chk("satcnt_after_rst", {16'h0, sat_count}, 32'h0);
    push_word(32'h3F800000);
    push_word(32'hFF800000);
    push_word(32'h3F000000);
    push_word(32'h7F800000);
    repeat (6) cycle();
    chk("satcnt_three", {16'h0, sat_count}, 32'd3);
    out_ready = 1'b0;
    push_word(32'hC0000000);
    t = 0;
    while (!out_valid && t < 10) begin cycle(); t++; end
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    cycle();
    sat_clr   = 1'b0;
    chk("satcnt_clr_priority", {16'h0, sat_count}, 32'h0);
    repeat (3) cycle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
